// File: rtl/count_seq_checker.sv
// count_seq_checker
//   Watches an up/down counter's count/direction outputs and checks that every
//   valid sample equals the previous sample +1 (dir=1) or -1 (dir=0), modulo
//   2^WIDTH. It must see LOCK_STEPS consecutive correct steps before it enforces
//   the rule. Once locked, each bad step is counted and reported.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | no reference value yet; the next valid sample seeds it
//   ACQUIRE  | counting consecutive good steps; mismatches just reseed
//   LOCKED   | step rule enforced; a mismatch is a reported error
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset of the checker
//   src_reset  in   observed counter reset, sampled synchronously
//   sample_en  in   count_in/dir_in valid this cycle
//   count_in   in   observed counter value
//   dir_in     in   observed direction (1 = up, 0 = down)
//   locked     out  step rule currently enforced
//   err_pulse  out  one-cycle pulse per detected step error
//   err_count  out  saturating total error count
//   expected   out  value the next valid sample must equal
//   last_bad   out  count_in of the most recent erroneous sample
module count_seq_checker #(
    parameter int WIDTH      = 8,
    parameter int ERR_W      = 8,
    parameter int LOCK_STEPS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src_reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] count_in,
    input  logic             dir_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected,
    output logic [WIDTH-1:0] last_bad
);

    localparam int GOOD_W = $clog2(LOCK_STEPS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [GOOD_W-1:0]   good_cnt_q,  good_cnt_d;
    logic [WIDTH-1:0]    expected_q,  expected_d;
    logic [WIDTH-1:0]    last_bad_q,  last_bad_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;
    logic                locked_q,    locked_d;
    logic                err_pulse_q, err_pulse_d;

    logic [WIDTH-1:0]    next_exp;
    logic                match;

    // Wrap-around in both directions falls out of modulo arithmetic.
    assign next_exp = dir_in ? (count_in + WIDTH'(1)) : (count_in - WIDTH'(1));
    assign match    = (count_in == expected_q);

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        expected_d  = expected_q;
        last_bad_d  = last_bad_q;
        err_count_d = err_count_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;

        if (src_reset) begin
            // The counter restarting is a legal discontinuity: resync silently,
            // keeping the error history.
            state_d    = IDLE;
            good_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (sample_en) begin
            expected_d = next_exp;
            case (state_q)
                IDLE: begin
                    good_cnt_d = '0;
                    state_d    = ACQUIRE;
                end
                ACQUIRE: begin
                    if (match) begin
                        if (good_cnt_q == GOOD_W'(LOCK_STEPS - 1)) begin
                            good_cnt_d = GOOD_W'(LOCK_STEPS);
                            state_d    = LOCKED;
                            locked_d   = 1'b1;
                        end else begin
                            good_cnt_d = good_cnt_q + GOOD_W'(1);
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        err_pulse_d = 1'b1;
                        last_bad_d  = count_in;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        locked_d   = 1'b0;
                        good_cnt_d = '0;
                        state_d    = ACQUIRE;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    good_cnt_d = '0;
                    locked_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            good_cnt_q  <= '0;
            expected_q  <= '0;
            last_bad_q  <= '0;
            err_count_q <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            expected_q  <= expected_d;
            last_bad_q  <= last_bad_d;
            err_count_q <= err_count_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign expected  = expected_q;
    assign last_bad  = last_bad_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker
//   Directed bench for count_seq_checker (WIDTH=8, ERR_W=2, LOCK_STEPS=2).
//   Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_count_seq_checker;

    logic       clk;
    logic       reset;
    logic       src_reset;
    logic       sample_en;
    logic [7:0] count_in;
    logic       dir_in;
    logic       locked;
    logic       err_pulse;
    logic [1:0] err_count;
    logic [7:0] expected;
    logic [7:0] last_bad;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulses = 0;

    count_seq_checker #(
        .WIDTH     (8),
        .ERR_W     (2),
        .LOCK_STEPS(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .src_reset(src_reset),
        .sample_en(sample_en),
        .count_in (count_in),
        .dir_in   (dir_in),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .expected (expected),
        .last_bad (last_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic sample(input logic [7:0] c, input logic d);
        sample_en = 1'b1;
        count_in  = c;
        dir_in    = d;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        if (err_pulse) n_pulses++;
    endtask

    task automatic src_pulse();
        src_reset = 1'b1;
        @(posedge clk);
        #1;
        src_reset = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        src_reset = 1'b0;
        sample_en = 1'b0;
        count_in  = '0;
        dir_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked",    32'(locked),    0);
        check("rst_err_pulse", 32'(err_pulse), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_expected",  32'(expected),  0);
        check("rst_last_bad",  32'(last_bad),  0);
        reset = 1'b0;
        idle_cycle();

        // 1: up run 0..3, locks after "2"
        sample(8'd0, 1'b1);
        check("t1_locked_0", 32'(locked),   0);
        check("t1_exp_0",    32'(expected), 1);
        sample(8'd1, 1'b1);
        check("t1_locked_1", 32'(locked),   0);
        sample(8'd2, 1'b1);
        check("t1_locked_2", 32'(locked),   1);
        sample(8'd3, 1'b1);
        check("t1_exp_3",    32'(expected), 4);
        check("t1_errcnt",   32'(err_count), 0);

        // 2: wrap up then wrap down
        src_pulse();
        check("t2_srcrst_unlock", 32'(locked), 0);
        sample(8'd252, 1'b1);
        sample(8'd253, 1'b1);
        sample(8'd254, 1'b1);
        check("t2_locked_254", 32'(locked), 1);
        sample(8'd255, 1'b1);
        check("t2_exp_255", 32'(expected), 0);
        sample(8'd0, 1'b1);
        check("t2_pulse_0",  32'(err_pulse), 0);
        check("t2_locked_0", 32'(locked),    1);
        sample(8'd1, 1'b0);
        check("t2_exp_1dn", 32'(expected), 0);
        sample(8'd0, 1'b0);
        check("t2_exp_0dn", 32'(expected), 255);
        sample(8'd255, 1'b0);
        check("t2_pulse_255dn", 32'(err_pulse), 0);
        sample(8'd254, 1'b0);
        check("t2_locked_end", 32'(locked),    1);
        check("t2_exp_end",    32'(expected),  253);
        check("t2_errcnt",     32'(err_count), 0);

        // 3: injected error while locked
        src_pulse();
        sample(8'd4, 1'b1);
        sample(8'd5, 1'b1);
        sample(8'd6, 1'b1);
        check("t3_locked_6", 32'(locked), 1);
        sample(8'd9, 1'b1);
        check("t3_pulse",    32'(err_pulse), 1);
        check("t3_errcnt",   32'(err_count), 1);
        check("t3_last_bad", 32'(last_bad),  9);
        check("t3_unlocked", 32'(locked),    0);
        check("t3_exp",      32'(expected),  10);
        idle_cycle();
        check("t3_pulse_gone", 32'(err_pulse), 0);
        sample(8'd10, 1'b1);
        check("t3_locked_10", 32'(locked), 0);
        sample(8'd11, 1'b1);
        check("t3_relock",     32'(locked),    1);
        check("t3_errcnt_end", 32'(err_count), 1);

        // 4: direction flip while locked
        src_pulse();
        sample(8'd18, 1'b1);
        sample(8'd19, 1'b1);
        sample(8'd20, 1'b1);
        sample(8'd21, 1'b0);
        check("t4_exp_flip", 32'(expected), 20);
        sample(8'd20, 1'b0);
        check("t4_pulse_20", 32'(err_pulse), 0);
        sample(8'd19, 1'b0);
        check("t4_pulse_19", 32'(err_pulse), 0);
        check("t4_locked",   32'(locked),    1);
        check("t4_exp",      32'(expected),  18);
        check("t4_errcnt",   32'(err_count), 1);

        // 5: gap of 5 idle cycles, then src_reset while locked
        repeat (5) idle_cycle();
        check("t5_gap_exp",    32'(expected), 18);
        check("t5_gap_locked", 32'(locked),   1);
        sample(8'd18, 1'b0);
        check("t5_after_gap_pulse", 32'(err_pulse), 0);
        check("t5_after_gap_exp",   32'(expected),  17);
        src_reset = 1'b1;
        sample(8'd99, 1'b1);
        src_reset = 1'b0;
        check("t5_src_locked",   32'(locked),    0);
        check("t5_src_pulse",    32'(err_pulse), 0);
        check("t5_src_errcnt",   32'(err_count), 1);
        check("t5_src_last_bad", 32'(last_bad),  9);
        check("t5_src_exp_hold", 32'(expected),  17);
        sample(8'd0, 1'b1);
        sample(8'd1, 1'b1);
        sample(8'd2, 1'b1);
        check("t5_relock", 32'(locked),    1);
        check("t5_errcnt", 32'(err_count), 1);

        // 6: five errors, count saturates at 3
        n_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] bad;
            bad = 8'(100 + i * 10);
            sample(bad, 1'b1);
            check("t6_pulse",    32'(err_pulse), 1);
            check("t6_last_bad", 32'(last_bad),  32'(bad));
            check("t6_errcnt",   32'(err_count), (i + 2 > 3) ? 3 : i + 2);
            sample(bad + 8'd1, 1'b1);
            sample(bad + 8'd2, 1'b1);
            check("t6_relock", 32'(locked), 1);
        end
        check("t6_pulses", 32'(n_pulses), 5);

        // async reset mid-run, no clock edge needed
        sample(8'd200, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_locked",    32'(locked),    0);
        check("ar_errcnt",    32'(err_count), 0);
        check("ar_expected",  32'(expected),  0);
        check("ar_last_bad",  32'(last_bad),  0);
        check("ar_err_pulse", 32'(err_pulse), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
